top: RTL and testbench

TOP -- requirements
Module: top

---
 rtl/top.sv | 315 +++++++++++++++++++++++++++++++
 tb/tb_top.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/top.sv
`default_nettype none
// ============================================================================
//  Module      : top (with sub-module front_sensor)
//  Description : Obstacle-avoiding rover controller. An ultrasonic front
//                sensor is ranged every measurement period; a small FSM runs
//                both motors forward while the path is clear and stops them
//                when an obstacle is close or the emergency stop is pressed.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports (top)
//    clkin     in   system clock (125 MHz), rising edge
//    btn[3:0]  in   [0] async active-low reset, [1] emergency stop, [3:2] unused
//    jc6       in   ultrasonic echo (asynchronous)
//    jc4       out  ultrasonic trigger
//    jc5/jc7   out  left / right motor PWM enable
//    je[6:0]   out  seven-segment a..g, active-low, shows the FSM state
//    jd[7:0]   out  front distance in cm, saturated at 255
//    led[3:0]  out  [0] FORWARD, [1] STOP, [2] synced echo, [3] heartbeat
//  Timing parameters default to the real-time values; they exist so the
//  divider and periods can be shortened for simulation.
// ============================================================================

// ----------------------------------------------------------------------------
//  front_sensor : trigger generation, echo synchronisation and echo timing.
//    clk, rst_n     clock and (already synchronised) active-low reset
//    i_tick         one-cycle 1 us strobe
//    i_echo         raw echo input
//    o_trig         trigger pulse, TRIG_TICKS wide at each period start
//    o_echo_sync    synchronised echo level
//    o_dist_cm      current distance value
// ----------------------------------------------------------------------------
module front_sensor #(
  parameter int PERIOD_TICKS  = 60000,
  parameter int TIMEOUT_TICKS = 30000,
  parameter int TRIG_TICKS    = 10,
  parameter int CM_TICKS      = 58
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_tick,
  input  logic        i_echo,
  output logic        o_trig,
  output logic        o_echo_sync,
  output logic [15:0] o_dist_cm
);

  localparam int c_pw = $clog2(PERIOD_TICKS);
  localparam int c_tw = $clog2(TIMEOUT_TICKS);
  localparam int c_sw = $clog2(CM_TICKS);

  localparam logic [c_pw-1:0] c_period_last  = c_pw'(PERIOD_TICKS - 1);
  localparam logic [c_pw-1:0] c_trig_len     = c_pw'(TRIG_TICKS);
  localparam logic [c_tw-1:0] c_timeout_last = c_tw'(TIMEOUT_TICKS - 1);
  localparam logic [c_sw-1:0] c_sub_last     = c_sw'(CM_TICKS - 1);

  logic [15:0]     dist_cm;
  logic            r_echo_m;
  logic            r_echo_s;
  logic            r_echo_d;
  logic [c_pw-1:0] r_period;
  logic            r_meas;
  logic            r_seen;
  logic [c_sw-1:0] r_sub;
  logic [15:0]     r_cm;
  logic [c_tw-1:0] r_echo_ticks;

  // Simulation back door: set_distance posts a value and flips a request
  // toggle; the register picks it up on the next edge while the output
  // shows it at once.
  logic [15:0]     sim_val;
  logic            sim_req;
  logic            r_sim_ack;
  logic            w_sim_pend;

  task set_distance(input logic [15:0] cm);
    sim_val = cm;
    sim_req = ~sim_req;
  endtask

  logic w_rise;
  logic w_fall;

  assign w_rise     = r_echo_s & ~r_echo_d;
  assign w_fall     = ~r_echo_s & r_echo_d;
  assign w_sim_pend = (sim_req != r_sim_ack);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_echo_m     <= 1'b0;
      r_echo_s     <= 1'b0;
      r_echo_d     <= 1'b0;
      r_period     <= '0;
      r_meas       <= 1'b0;
      r_seen       <= 1'b0;
      r_sub        <= '0;
      r_cm         <= '0;
      r_echo_ticks <= '0;
      dist_cm      <= '0;
      // Discard any request posted before or during reset.
      r_sim_ack    <= sim_req;
    end else begin
      r_echo_m <= i_echo;
      r_echo_s <= r_echo_m;
      r_echo_d <= r_echo_s;

      if (i_tick) begin
        if (r_period == c_period_last) begin
          r_period <= '0;
          if (!r_seen) begin
            dist_cm <= 16'hFFFF;
          end
          r_seen <= 1'b0;
        end else begin
          r_period <= r_period + 1'b1;
        end
      end

      if (w_rise) begin
        r_meas       <= 1'b1;
        r_seen       <= 1'b1;
        r_cm         <= '0;
        // A tick coinciding with the rising edge belongs to the pulse.
        r_sub        <= c_sw'(i_tick);
        r_echo_ticks <= c_tw'(i_tick);
      end else if (r_meas) begin
        if (w_fall) begin
          dist_cm <= r_cm;
          r_meas  <= 1'b0;
        end else if (i_tick) begin
          if (r_echo_ticks == c_timeout_last) begin
            dist_cm <= 16'hFFFF;
            r_meas  <= 1'b0;
          end else begin
            r_echo_ticks <= r_echo_ticks + 1'b1;
          end
          if (r_sub == c_sub_last) begin
            r_sub <= '0;
            r_cm  <= r_cm + 16'd1;
          end else begin
            r_sub <= r_sub + 1'b1;
          end
        end
      end

      if (w_sim_pend) begin
        dist_cm   <= sim_val;
        r_sim_ack <= sim_req;
      end
    end
  end

  // rst_n is a registered, glitch-free level here; gating with it keeps the
  // trigger low in reset and makes the first pulse exactly TRIG_TICKS wide.
  assign o_trig      = rst_n & (r_period < c_trig_len);
  assign o_echo_sync = r_echo_s;
  assign o_dist_cm   = w_sim_pend ? sim_val : dist_cm;

endmodule

// ----------------------------------------------------------------------------
//  top
// ----------------------------------------------------------------------------
module top #(
  parameter int TICK_DIV      = 125,
  parameter int PERIOD_TICKS  = 60000,
  parameter int TIMEOUT_TICKS = 30000,
  parameter int PWM_TICKS     = 1000,
  parameter int HB_TICKS      = 500000
) (
  input  logic       clkin,
  input  logic [3:0] btn,
  input  logic       jc6,
  output logic       jc4,
  output logic       jc5,
  output logic       jc7,
  output logic [6:0] je,
  output logic [7:0] jd,
  output logic [3:0] led
);

  localparam int c_dw = $clog2(TICK_DIV);
  localparam int c_ww = $clog2(PWM_TICKS);
  localparam int c_hw = $clog2(HB_TICKS);

  localparam logic [c_dw-1:0] c_div_last = c_dw'(TICK_DIV - 1);
  localparam logic [c_ww-1:0] c_pwm_last = c_ww'(PWM_TICKS - 1);
  localparam logic [c_ww-1:0] c_pwm_half = c_ww'(PWM_TICKS / 2);
  localparam logic [c_hw-1:0] c_hb_last  = c_hw'(HB_TICKS - 1);

  localparam logic [1:0] c_idle    = 2'b00;
  localparam logic [1:0] c_forward = 2'b01;
  localparam logic [1:0] c_stop    = 2'b10;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] c_seg_f    = 7'b0001110;
  localparam logic [6:0] c_seg_s    = 7'b0010010;
  localparam logic [6:0] c_seg_dash = 7'b0111111;

  localparam logic [15:0] c_near_cm = 16'd13;

  logic clk;
  assign clk = clkin;

  logic w_unused_btn;
  assign w_unused_btn = &{1'b0, btn[3:2]};

  // Reset: asserts asynchronously, releases on a clock edge.
  logic r_rst_m;
  logic r_rst_n;

  always_ff @(posedge clk or negedge btn[0]) begin
    if (!btn[0]) begin
      r_rst_m <= 1'b0;
      r_rst_n <= 1'b0;
    end else begin
      r_rst_m <= 1'b1;
      r_rst_n <= r_rst_m;
    end
  end

  logic            r_stop_m;
  logic            r_stop_s;
  logic [c_dw-1:0] r_div;
  logic [1:0]      r_state;
  logic [c_ww-1:0] r_pwm;
  logic [c_hw-1:0] r_hb_cnt;
  logic            r_hb;

  logic            w_tick;
  logic            w_trig;
  logic            w_echo_s;
  logic [15:0]     w_dist;

  assign w_tick = (r_div == c_div_last);

  front_sensor #(
    .PERIOD_TICKS  (PERIOD_TICKS),
    .TIMEOUT_TICKS (TIMEOUT_TICKS),
    .TRIG_TICKS    (10),
    .CM_TICKS      (58)
  ) front_sensor (
    .clk         (clk),
    .rst_n       (r_rst_n),
    .i_tick      (w_tick),
    .i_echo      (jc6),
    .o_trig      (w_trig),
    .o_echo_sync (w_echo_s),
    .o_dist_cm   (w_dist)
  );

  always_ff @(posedge clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      r_stop_m <= 1'b0;
      r_stop_s <= 1'b0;
      r_div    <= '0;
      r_state  <= c_idle;
      r_pwm    <= '0;
      r_hb_cnt <= '0;
      r_hb     <= 1'b0;
    end else begin
      r_stop_m <= btn[1];
      r_stop_s <= r_stop_m;

      if (w_tick) begin
        r_div <= '0;
      end else begin
        r_div <= r_div + 1'b1;
      end

      if (w_tick) begin
        // Every state, IDLE included, re-evaluates on each tick.
        if (r_stop_s) begin
          r_state <= c_stop;
        end else if (w_dist > c_near_cm) begin
          r_state <= c_forward;
        end else begin
          r_state <= c_stop;
        end

        if (r_pwm == c_pwm_last) begin
          r_pwm <= '0;
        end else begin
          r_pwm <= r_pwm + 1'b1;
        end

        if (r_hb_cnt == c_hb_last) begin
          r_hb_cnt <= '0;
          r_hb     <= ~r_hb;
        end else begin
          r_hb_cnt <= r_hb_cnt + 1'b1;
        end
      end
    end
  end

  logic w_fwd;
  assign w_fwd = (r_state == c_forward);

  always_comb begin
    je = c_seg_dash;
    case (r_state)
      c_forward: je = c_seg_f;
      c_stop:    je = c_seg_s;
      default:   je = c_seg_dash;
    endcase
  end

  assign jc4 = w_trig;
  assign jc5 = w_fwd & (r_pwm < c_pwm_half);
  assign jc7 = w_fwd & (r_pwm < c_pwm_half);
  assign jd  = (w_dist[15:8] == 8'd0) ? w_dist[7:0] : 8'hFF;
  assign led = {r_hb, w_echo_s, (r_state == c_stop), w_fwd};

endmodule
`default_nettype wire

// File: tb/tb_top.sv
`default_nettype none
// ============================================================================
//  Module      : tb_top
//  Description : Directed self-checking bench for top. Timing parameters are
//                shortened so the whole run stays short; all expectations
//                are written in terms of those parameters.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_top;

  localparam int TD  = 4;
  localparam int PER = 3000;
  localparam int TO  = 1500;
  localparam int PWM = 100;
  localparam int HB  = 2000;

  localparam logic [6:0] SEG_F    = 7'b0001110;
  localparam logic [6:0] SEG_S    = 7'b0010010;
  localparam logic [6:0] SEG_DASH = 7'b0111111;

  logic       clk = 1'b0;
  logic [3:0] btn;
  logic       jc6;
  logic       jc4, jc5, jc7;
  logic [6:0] je;
  logic [7:0] jd;
  logic [3:0] led;

  int n_chk = 0;
  int n_err = 0;

  top #(
    .TICK_DIV      (TD),
    .PERIOD_TICKS  (PER),
    .TIMEOUT_TICKS (TO),
    .PWM_TICKS     (PWM),
    .HB_TICKS      (HB)
  ) dut (
    .clkin (clk),
    .btn   (btn),
    .jc6   (jc6),
    .jc4   (jc4),
    .jc5   (jc5),
    .jc7   (jc7),
    .je    (je),
    .jd    (jd),
    .led   (led)
  );

  always #4 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Trigger monitor: width of the last pulse and spacing of the last two.
  int   rise_cnt  = 0;
  int   last_rise = 0;
  int   last_int  = 0;
  int   last_w    = 0;
  logic jc4_d     = 1'b0;
  always @(negedge clk) begin
    if (jc4 && !jc4_d) begin
      if (rise_cnt > 0) last_int = cyc - last_rise;
      last_rise = cyc;
      rise_cnt  = rise_cnt + 1;
    end
    if (!jc4 && jc4_d) last_w = cyc - last_rise;
    jc4_d = jc4;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int hi, mism, rises, k, rel;
  logic p5;

  initial begin
    btn = 4'b0000;
    jc6 = 1'b0;

    // Reset held 5 us.
    wait_cyc(625);
    check("rst_jc4", jc4, 0);
    check("rst_jc5", jc5, 0);
    check("rst_jc7", jc7, 0);
    check("rst_je", je, SEG_DASH);
    check("rst_jd", jd, 0);
    check("rst_led", led, 4'b0000);

    @(negedge clk) btn[0] = 1'b1;
    wait_cyc(1);
    check("idle_je", je, SEG_DASH);
    wait_cyc(3 * TD + 2);
    check("stop0_led", led, 4'b0010);
    check("stop0_je", je, SEG_S);
    check("stop0_jd", jd, 0);
    check("stop0_jc5", jc5, 0);
    check("stop0_jc7", jc7, 0);

    // Clear path.
    wait_cyc(10 * TD);
    dut.front_sensor.set_distance(16'd20);
    wait_cyc(2 * TD);
    check("fwd_led", led[1:0], 2'b01);
    check("fwd_je", je, SEG_F);
    check("fwd_jd", jd, 20);

    // Two full PWM periods: 50 % duty, two rising edges, both sides equal.
    hi = 0; mism = 0; rises = 0; p5 = jc5;
    repeat (2 * PWM * TD) begin
      @(posedge clk); #1;
      hi += int'(jc5);
      if (jc5 !== jc7) mism++;
      if (jc5 && !p5) rises++;
      p5 = jc5;
    end
    check("pwm_high", hi, PWM * TD);
    check("pwm_rises", rises, 2);
    check("pwm_lr", mism, 0);

    // Threshold boundary.
    dut.front_sensor.set_distance(16'd13);
    wait_cyc(2 * TD);
    check("thr13", led[1:0], 2'b10);
    check("thr13_pwm", jc5, 0);
    dut.front_sensor.set_distance(16'd14);
    wait_cyc(2 * TD);
    check("thr14", led[1:0], 2'b01);
    check("thr14_jd", jd, 14);

    // Emergency stop.
    dut.front_sensor.set_distance(16'd20);
    wait_cyc(2 * TD);
    btn[1] = 1'b1;
    wait_cyc(2 * TD + 3);
    check("estop", led[1:0], 2'b10);
    check("estop_je", je, SEG_S);
    btn[1] = 1'b0;
    wait_cyc(2 * TD + 3);
    check("estop_rel", led[1:0], 2'b01);

    // 580 us echo -> 10 cm.
    jc6 = 1'b1;
    wait_cyc(100 * TD);
    check("echo_led2", led[2], 1);
    wait_cyc(480 * TD);
    jc6 = 1'b0;
    wait_cyc(3 * TD);
    check("echo10_jd", jd, 10);
    check("echo10_st", led[1:0], 2'b10);

    // Echo stuck high past the timeout -> no obstacle.
    jc6 = 1'b1;
    wait_cyc((TO + 20) * TD);
    check("tmo_jd", jd, 8'hFF);
    check("tmo_st", led[1:0], 2'b01);
    check("tmo_dist", dut.front_sensor.o_dist_cm, 16'hFFFF);
    jc6 = 1'b0;

    // Trigger repetition and width.
    k = 0;
    while (rise_cnt < 2 && k < (PER + 50) * TD) begin
      @(posedge clk); k++;
    end
    k = 0;
    while (jc4 && k < 20 * TD) begin
      @(posedge clk); k++;
    end
    wait_cyc(2);
    check("trig_seen", rise_cnt, 2);
    check("trig_period", last_int, PER * TD);
    check("trig_width", last_w, 10 * TD);

    // Distance changed mid-echo, then overwritten by the falling edge.
    jc6 = 1'b1;
    wait_cyc(100 * TD);
    dut.front_sensor.set_distance(16'd5);
    wait_cyc(2 * TD);
    check("mid_st", led[1:0], 2'b10);
    check("mid_jd", jd, 5);
    wait_cyc((1160 - 102) * TD);
    jc6 = 1'b0;
    wait_cyc(3 * TD);
    check("mid_fall_jd", jd, 20);
    check("mid_fall_st", led[1:0], 2'b01);

    // Reset in the middle of a measurement.
    jc6 = 1'b1;
    wait_cyc(50 * TD);
    btn[0] = 1'b0;
    #1;
    check("arst_jd", jd, 0);
    check("arst_je", je, SEG_DASH);
    check("arst_led", led, 4'b0000);
    check("arst_jc5", jc5, 0);
    jc6 = 1'b0;
    wait_cyc(5 * TD);
    @(negedge clk) btn[0] = 1'b1;
    rel = cyc;
    wait_cyc(4);
    check("retrig", jc4, 1);
    wait_cyc(3 * TD);
    check("rel_st", led[1:0], 2'b10);

    // Heartbeat toggles after HB ticks.
    while (cyc - rel < (HB - 2) * TD) @(posedge clk);
    #1;
    check("hb_early", led[3], 0);
    k = 0;
    while (!led[3] && k < 4 * TD) begin
      @(posedge clk); #1; k++;
    end
    check("hb_toggle", led[3], 1);

    // A period with no echo at all ends as "no obstacle".
    while (cyc - rel < (PER - 3) * TD) @(posedge clk);
    #1;
    check("noecho_pre", led[1:0], 2'b10);
    while (cyc - rel < (PER + 3) * TD) @(posedge clk);
    #1;
    check("noecho_jd", jd, 8'hFF);
    check("noecho_st", led[1:0], 2'b01);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
